// File: rtl/chip8_bus_pkg.sv
// rtl/chip8_bus_pkg.sv - shared constants and types for the CHIP-8 bus arbiter
package chip8_bus_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;
   localparam int N_REQ  = 2;

   // Requester ids: CPU core and display/DMA fetch engine
   localparam logic REQ_CPU  = 1'b0;
   localparam logic REQ_DISP = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   // Turn a requester id into its one-hot lane
   function automatic logic [1:0] id_to_onehot(input logic id);
      return id ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/chip8_rr_pick.sv
// rtl/chip8_rr_pick.sv - combinational 2-way round-robin selector
module chip8_rr_pick
   import chip8_bus_pkg::*;
(
   input  logic [1:0] valid,
   input  logic       last_grant,
   output logic [1:0] grant_onehot,
   output logic       grant_id
);

   // A lone requester always wins; on a tie the one not granted last time wins
   always_comb begin
      grant_onehot = 2'b00;
      grant_id     = last_grant;
      case (valid)
         2'b01: begin
            grant_onehot = id_to_onehot(REQ_CPU);
            grant_id     = REQ_CPU;
         end
         2'b10: begin
            grant_onehot = id_to_onehot(REQ_DISP);
            grant_id     = REQ_DISP;
         end
         2'b11: begin
            grant_onehot = id_to_onehot(~last_grant);
            grant_id     = ~last_grant;
         end
         default: begin
            grant_onehot = 2'b00;
            grant_id     = last_grant;
         end
      endcase
   end

endmodule

// File: rtl/chip8_bus_arbiter.sv
// rtl/chip8_bus_arbiter.sv - round-robin arbiter sharing the CHIP-8 bus between CPU and display fetch
module chip8_bus_arbiter
   import chip8_bus_pkg::*;
#(
   parameter int WAIT_CYCLES = 1,
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            req_valid,
   output logic [1:0]            req_ready,
   input  logic [1:0]            req_we,
   input  logic [2*ADDR_W-1:0]   req_addr,
   input  logic [2*DATA_W-1:0]   req_wdata,
   output logic [1:0]            rsp_valid,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  bus_en,
   output logic                  bus_we,
   output logic [ADDR_W-1:0]     bus_addr,
   output logic [DATA_W-1:0]     bus_wdata,
   input  logic [DATA_W-1:0]     bus_rdata,
   output logic                  busy
);

   state_t              r_state;
   logic [3:0]          r_wait_cnt;
   logic                r_last_grant;
   logic                r_bus_en;
   logic                r_bus_we;
   logic [ADDR_W-1:0]   r_bus_addr;
   logic [DATA_W-1:0]   r_bus_wdata;
   logic [1:0]          r_rsp_valid;
   logic [DATA_W-1:0]   r_rsp_rdata;

   logic [1:0]          w_grant_onehot;
   logic                w_grant_id;
   logic                w_idle;
   logic [1:0]          w_ready;
   logic                w_handshake;
   logic                w_sel_we;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [DATA_W-1:0]   w_sel_wdata;

   chip8_rr_pick u_rr_pick (
      .valid        (req_valid),
      .last_grant   (r_last_grant),
      .grant_onehot (w_grant_onehot),
      .grant_id     (w_grant_id)
   );

   // Ready is offered only in IDLE and never while reset is being applied,
   // so a handshake cannot coincide with a reset edge
   assign w_idle      = (r_state == IDLE);
   assign w_ready     = (w_idle && rst_n) ? w_grant_onehot : 2'b00;
   assign w_handshake = |(req_valid & w_ready);

   // Payload of the requester that wins this cycle
   assign w_sel_we    = w_grant_id ? req_we[1] : req_we[0];
   assign w_sel_addr  = w_grant_id ? req_addr[2*ADDR_W-1:ADDR_W]    : req_addr[ADDR_W-1:0];
   assign w_sel_wdata = w_grant_id ? req_wdata[2*DATA_W-1:DATA_W]   : req_wdata[DATA_W-1:0];

   // Transaction FSM: latch on handshake, hold the bus for WAIT_CYCLES+1 cycles, then pulse the response
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_wait_cnt   <= 4'd0;
         r_last_grant <= 1'b1;
         r_bus_en     <= 1'b0;
         r_bus_we     <= 1'b0;
         r_bus_addr   <= '0;
         r_bus_wdata  <= '0;
         r_rsp_valid  <= 2'b00;
         r_rsp_rdata  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_handshake) begin
                  r_bus_en     <= 1'b1;
                  r_bus_we     <= w_sel_we;
                  r_bus_addr   <= w_sel_addr;
                  r_bus_wdata  <= w_sel_wdata;
                  r_last_grant <= w_grant_id;
                  r_wait_cnt   <= 4'(WAIT_CYCLES);
                  r_state      <= ACCESS;
               end
            end
            ACCESS: begin
               if (r_wait_cnt == 4'd0) begin
                  // Writes return an acknowledge only, so their data lane stays zero
                  r_bus_en    <= 1'b0;
                  r_rsp_rdata <= r_bus_we ? '0 : bus_rdata;
                  r_rsp_valid <= id_to_onehot(r_last_grant);
                  r_state     <= RESP;
               end else begin
                  r_wait_cnt  <= r_wait_cnt - 4'd1;
               end
            end
            RESP: begin
               r_rsp_valid <= 2'b00;
               r_rsp_rdata <= '0;
               r_state     <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign req_ready = w_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign bus_en    = r_bus_en;
   assign bus_we    = r_bus_we;
   assign bus_addr  = r_bus_addr;
   assign bus_wdata = r_bus_wdata;
   assign busy      = (r_state != IDLE);

endmodule
